alu_move_unit: RTL and testbench

Command-side driver for the four-cell accumulating ALU. It turns a stream of move commands into the ALU's operand and result signals. A "push" delivers an operand to one op cell. A "pop" reads the selected cell's result and flags and then clears that cell. It sits between the move/transport sequencer and the ALU, and owns all ALU input and output signal sequencing.

---
 rtl/alu_move_unit_pkg.sv | 31 +++
 rtl/alu_move_unit.sv | 117 +++++++++++
 tb/tb_alu_move_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_move_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_move_unit_pkg
// Description : Shared constants for the ALU move unit: op-cell select codes,
//               result flag bit positions and the command FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_move_unit_pkg;

    // Op cell select codes (also the ALU operand/result select encoding)
    localparam logic [1:0] OP_PLUS = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    // Bit positions inside the 5-bit ALU flag vector
    localparam int FLAG_PARITY   = 4;
    localparam int FLAG_ZERO     = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_NEGATIVE = 1;
    localparam int FLAG_CARRY    = 0;

    // Command FSM state encodings
    localparam int         STATE_W  = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PUSH  = 2'd1;
    localparam logic [1:0] ST_POP   = 2'd2;
    localparam logic [1:0] ST_RSP   = 2'd3;

endpackage : alu_move_unit_pkg
`default_nettype wire

// File: rtl/alu_move_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_move_unit
// Description : Command-side driver for the four-cell accumulating ALU.
//               Push commands deliver an operand to one op cell; pop commands
//               read the selected cell's result and flags, clear the cell and
//               return a response.
// Revision    : 1.0 - initial release
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready command handshake
//   i_cmd_pop/op/data       command: push (0) or pop (1), op cell, operand
//   o_alu_input_op/data     operand select and data to the ALU
//   o_alu_data_valid        one-cycle operand strobe to the ALU
//   o_alu_output_op         result select to the ALU
//   o_alu_result_empty      one-cycle result-consume strobe to the ALU
//   i_alu_result_*          selected cell valid/value/flags from the ALU
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_data/flags/error  popped value, flags, empty-cell error
// ============================================================================
module alu_move_unit #(
    parameter bit WAIT_ON_EMPTY = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_pop,
    input  logic [1:0]  i_cmd_op,
    input  logic [31:0] i_cmd_data,
    output logic [1:0]  o_alu_input_op,
    output logic        o_alu_data_valid,
    output logic [31:0] o_alu_data,
    output logic [1:0]  o_alu_output_op,
    output logic        o_alu_result_empty,
    input  logic        i_alu_result_valid,
    input  logic [31:0] i_alu_result,
    input  logic [4:0]  i_alu_result_flags,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic [4:0]  o_rsp_flags,
    output logic        o_rsp_error
);
    import alu_move_unit_pkg::*;

    logic [STATE_W-1:0] r_state;
    logic [1:0]         r_alu_input_op;
    logic [31:0]        r_alu_data;
    logic [1:0]         r_alu_output_op;
    logic [31:0]        r_rsp_data;
    logic [4:0]         r_rsp_flags;
    logic               r_rsp_error;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_alu_input_op  <= '0;
            r_alu_data      <= '0;
            r_alu_output_op <= '0;
            r_rsp_data      <= '0;
            r_rsp_flags     <= '0;
            r_rsp_error     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        if (i_cmd_pop) begin
                            r_alu_output_op <= i_cmd_op;
                            r_state         <= ST_POP;
                        end else begin
                            r_alu_input_op <= i_cmd_op;
                            r_alu_data     <= i_cmd_data;
                            r_state        <= ST_PUSH;
                        end
                    end
                end
                // The ALU absorbs the operand at the end of this cycle
                ST_PUSH: r_state <= ST_IDLE;
                ST_POP: begin
                    if (i_alu_result_valid) begin
                        r_rsp_data  <= i_alu_result;
                        r_rsp_flags <= i_alu_result_flags;
                        r_rsp_error <= 1'b0;
                        r_state     <= ST_RSP;
                    end else if (!WAIT_ON_EMPTY) begin
                        r_rsp_data  <= '0;
                        r_rsp_flags <= '0;
                        r_rsp_error <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (i_rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Ready is masked by reset so the block looks busy until reset releases
    assign o_cmd_ready        = (r_state == ST_IDLE) && !i_rst;
    // Strobes decode straight from state so an async reset drops them at once
    assign o_alu_data_valid   = (r_state == ST_PUSH);
    assign o_alu_result_empty = (r_state == ST_POP) && i_alu_result_valid;
    assign o_rsp_valid        = (r_state == ST_RSP);

    assign o_alu_input_op  = r_alu_input_op;
    assign o_alu_data      = r_alu_data;
    assign o_alu_output_op = r_alu_output_op;
    assign o_rsp_data      = r_rsp_data;
    assign o_rsp_flags     = r_rsp_flags;
    assign o_rsp_error     = r_rsp_error;

endmodule : alu_move_unit
`default_nettype wire

// File: tb/tb_alu_move_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_move_unit
// Description : Self-checking bench for alu_move_unit. One instance (no wait
//               on empty) drives a behavioural four-cell accumulating ALU;
//               a second instance (wait on empty) has its ALU side driven
//               directly by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_move_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance 0 (WAIT_ON_EMPTY = 0) ----------------
    logic        cmd_valid = 1'b0, cmd_pop = 1'b0, rsp_ready = 1'b1;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready, dv, re, rsp_valid, rsp_error;
    logic [1:0]  in_op, out_op;
    logic [31:0] alu_data, rsp_data;
    logic [4:0]  rsp_flags;
    logic        alu_valid;
    logic [31:0] alu_result;
    logic [4:0]  alu_flags;

    alu_move_unit #(.WAIT_ON_EMPTY(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_pop(cmd_pop), .i_cmd_op(cmd_op), .i_cmd_data(cmd_data),
        .o_alu_input_op(in_op), .o_alu_data_valid(dv), .o_alu_data(alu_data),
        .o_alu_output_op(out_op), .o_alu_result_empty(re),
        .i_alu_result_valid(alu_valid), .i_alu_result(alu_result),
        .i_alu_result_flags(alu_flags),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_flags(rsp_flags), .o_rsp_error(rsp_error)
    );

    // ---------------- instance 1 (WAIT_ON_EMPTY = 1) ----------------
    logic        c1_valid = 1'b0, c1_rsp_ready = 1'b1;
    logic        c1_ready, dv1, re1, rsp_valid1, rsp_error1;
    logic [1:0]  in_op1, out_op1;
    logic [31:0] alu_data1, rsp_data1;
    logic [4:0]  rsp_flags1;
    logic        a1_valid = 1'b0;
    logic [31:0] a1_result = 32'd0;
    logic [4:0]  a1_flags = 5'd0;

    alu_move_unit #(.WAIT_ON_EMPTY(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(c1_valid), .o_cmd_ready(c1_ready),
        .i_cmd_pop(1'b1), .i_cmd_op(2'b01), .i_cmd_data(32'd0),
        .o_alu_input_op(in_op1), .o_alu_data_valid(dv1), .o_alu_data(alu_data1),
        .o_alu_output_op(out_op1), .o_alu_result_empty(re1),
        .i_alu_result_valid(a1_valid), .i_alu_result(a1_result),
        .i_alu_result_flags(a1_flags),
        .o_rsp_valid(rsp_valid1), .i_rsp_ready(c1_rsp_ready),
        .o_rsp_data(rsp_data1), .o_rsp_flags(rsp_flags1), .o_rsp_error(rsp_error1)
    );

    // ---------------- behavioural accumulating ALU ----------------
    logic [31:0] cell_val [4];
    logic [4:0]  cell_flg [4];
    logic        cell_vld [4];

    // Returns {parity, zero, overflow, negative, carry, value}
    function automatic logic [36:0] alu_calc(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01:   r = a & b;
            2'b10:   r = a | b;
            default: r = a ^ b;
        endcase
        return {^r, (r == 32'd0), v, r[31], c, r};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cell_val[i] <= 32'd0;
                cell_flg[i] <= 5'd0;
                cell_vld[i] <= 1'b0;
            end
        end else begin
            if (dv) begin
                if (!cell_vld[in_op]) begin
                    cell_val[in_op] <= alu_data;
                    cell_flg[in_op] <= {^alu_data, (alu_data == 32'd0), 1'b0, alu_data[31], 1'b0};
                end else begin
                    cell_val[in_op] <= alu_calc(in_op, cell_val[in_op], alu_data) >> 0;
                    cell_flg[in_op] <= alu_calc(in_op, cell_val[in_op], alu_data) >> 32;
                end
                cell_vld[in_op] <= 1'b1;
            end
            if (re) cell_vld[out_op] <= 1'b0;
        end
    end

    assign alu_valid  = cell_vld[out_op];
    assign alu_result = cell_val[out_op];
    assign alu_flags  = cell_flg[out_op];

    // Result-consume pulses seen by instance 0, sampled mid-cycle
    int re_cnt = 0;
    always @(negedge clk) if (re) re_cnt <= re_cnt + 1;

    // ---------------- checking and stimulus tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_push(input logic [1:0] op, input logic [31:0] d);
        wait_ready();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_pop = 1'b0; cmd_op = op; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (dv !== 1'b1 || alu_data !== d || in_op !== op) check("push_drive", {dv, in_op, alu_data[28:0]}, {1'b1, op, d[28:0]});
        @(negedge clk);
    endtask

    // Pops a cell; with hold=1 it returns while the response is still pending
    task automatic do_pop(input logic [1:0] op, input bit hold,
                          output logic [31:0] d, output logic [4:0] f,
                          output logic e, output int lat, output int pulses);
        int c0;
        int n;
        wait_ready();
        @(negedge clk);
        c0 = re_cnt;
        cmd_valid = 1'b1; cmd_pop = 1'b1; cmd_op = op;
        rsp_ready = !hold;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            lat++;
            n++;
        end
        if (n == 20) check("pop_timeout", 32'd0, 32'd1);
        d = rsp_data; f = rsp_flags; e = rsp_error;
        if (!hold) @(negedge clk);
        pulses = re_cnt - c0;
    endtask

    // ---------------- test sequence ----------------
    logic [31:0] d;
    logic [4:0]  f;
    logic        e;
    int          lat, pulses;

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        check("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_strobes", {28'd0, dv, re, rsp_valid, rsp_error}, 32'd0);
        check("reset_regs", {in_op, out_op, rsp_flags} | alu_data | rsp_data, 32'd0);

        // Reset asserted while in PUSH
        @(negedge clk);
        cmd_valid = 1'b1; cmd_pop = 1'b0; cmd_op = 2'b00; cmd_data = 32'd99;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("push_pulse", {31'd0, dv}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_drops_valid", {31'd0, dv}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Empty plus cell, no wait: error, latency 2, no clear pulse
        do_pop(2'b00, 1'b0, d, f, e, lat, pulses);
        check("empty_err", {31'd0, e}, 32'd1);
        check("empty_data", d, 32'd0);
        check("empty_lat", lat, 32'd2);
        check("empty_pulses", pulses, 32'd0);

        // Plus: 5 + 7
        do_push(2'b00, 32'd5);
        do_push(2'b00, 32'd7);
        do_pop(2'b00, 1'b0, d, f, e, lat, pulses);
        check("plus_data", d, 32'd12);
        check("plus_flags", {27'd0, f}, 32'd0);
        check("plus_err", {31'd0, e}, 32'd0);
        check("plus_pulses", pulses, 32'd1);
        do_pop(2'b00, 1'b0, d, f, e, lat, pulses);
        check("plus_repop_err", {31'd0, e}, 32'd1);

        // Xor to zero: only the zero flag set
        do_push(2'b11, 32'hFFFF0000);
        do_push(2'b11, 32'hFFFF0000);
        do_pop(2'b11, 1'b0, d, f, e, lat, pulses);
        check("xor_data", d, 32'd0);
        check("xor_flags", {27'd0, f}, 32'h08);

        // Response backpressure on and(0xF0, 0x3C)
        do_push(2'b01, 32'hF0);
        do_push(2'b01, 32'h3C);
        do_pop(2'b01, 1'b1, d, f, e, lat, pulses);
        for (int i = 0; i < 4; i++) begin
            check("bp_data", rsp_data, 32'h30);
            check("bp_busy", {30'd0, cmd_ready, rsp_valid}, 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {31'd0, cmd_ready}, 32'd1);

        // Interleaved op cells
        do_push(2'b10, 32'h1);
        do_push(2'b01, 32'hFF);
        do_push(2'b10, 32'h2);
        do_pop(2'b10, 1'b0, d, f, e, lat, pulses);
        check("mix_or", d, 32'h3);
        do_pop(2'b01, 1'b0, d, f, e, lat, pulses);
        check("mix_and", d, 32'hFF);
        check("mix_and_err", {31'd0, e}, 32'd0);
        do_pop(2'b11, 1'b0, d, f, e, lat, pulses);
        check("mix_xor_err", {31'd0, e}, 32'd1);

        // Wait-on-empty instance stalls until the cell turns valid
        @(negedge clk);
        c1_valid = 1'b1;
        @(negedge clk);
        c1_valid = 1'b0;
        check("w1_out_op", {30'd0, out_op1}, 32'd1);
        repeat (5) @(negedge clk);
        check("w1_stall", {29'd0, rsp_valid1, re1, c1_ready}, 32'd0);
        a1_valid = 1'b1; a1_result = 32'hABCD1234; a1_flags = 5'h12;
        #1;
        check("w1_clear_pulse", {31'd0, re1}, 32'd1);
        @(negedge clk);
        a1_valid = 1'b0;
        check("w1_rsp", {30'd0, rsp_valid1, rsp_error1}, 32'd2);
        check("w1_data", rsp_data1, 32'hABCD1234);
        check("w1_flags", {27'd0, rsp_flags1}, 32'h12);
        @(negedge clk);
        check("w1_idle", {31'd0, c1_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_move_unit
`default_nettype wire
